// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, constants and step function for the 8-bit Fibonacci LFSR
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps at bits 0,2,3,4 of a right-shifting register: x^8+x^6+x^5+x^4+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'b0001_1101;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } ctrlState_t;

    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] q);
        return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// rtl/lfsr8_step.sv - 8-bit Fibonacci LFSR register with load (priority) and step
module lfsr8_step
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = lfsr_pkg::DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              syncReset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (syncReset) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsrNext(state);
        end
    end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// rtl/lfsr_burst_ctrl.sv - burst sequencer: loads the LFSR and steps it once per accepted word
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int                LEN_W        = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 8'h80
) (
    input  logic              clk,
    input  logic              syncReset,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              word_valid,
    output logic [LFSR_W-1:0] word_data,
    input  logic              word_ready
);

    ctrlState_t        state;
    ctrlState_t        nextState;
    logic [LFSR_W-1:0] seedQ;
    logic [LEN_W-1:0]  lenQ;
    logic [LEN_W-1:0]  count;
    logic              endAborted;
    logic              xfer;
    logic              lfsrLoad;
    logic [LFSR_W-1:0] loadSeed;

    // Abort beats a transfer in the same cycle, so the presented word is neither stepped nor counted.
    assign xfer     = (state == RUN) && word_ready && !abort;
    assign lfsrLoad = (state == LOAD) && !abort && (lenQ != '0);
    assign loadSeed = (seedQ == '0) ? DEFAULT_SEED : seedQ;

    lfsr8_step #(
        .RESET_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .syncReset(syncReset),
        .load     (lfsrLoad),
        .seed     (loadSeed),
        .step     (xfer),
        .state    (word_data)
    );

    always_comb begin
        nextState  = state;
        endAborted = 1'b0;
        case (state)
            IDLE: begin
                if (start) nextState = LOAD;
            end
            LOAD: begin
                // A zero-length burst still spends this cycle busy but leaves the LFSR untouched.
                if (abort) begin
                    nextState  = DONE;
                    endAborted = 1'b1;
                end else if (lenQ == '0) begin
                    nextState = DONE;
                end else begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    nextState  = DONE;
                    endAborted = 1'b1;
                end else if (word_ready && (count == LEN_W'(1))) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (syncReset) begin
            state      <= IDLE;
            seedQ      <= '0;
            lenQ       <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state <= nextState;
            if ((state == IDLE) && start) begin
                seedQ <= seed;
                lenQ  <= len;
            end
            if (lfsrLoad) begin
                count <= lenQ;
            end else if (xfer) begin
                count <= count - LEN_W'(1);
            end
            // Status outputs are flops driven from the next state so they line up with it exactly.
            busy       <= (nextState == LOAD) || (nextState == RUN);
            done       <= (nextState == DONE);
            aborted    <= endAborted;
            word_valid <= (nextState == RUN);
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb/tb_lfsr_burst_ctrl.sv - directed self-checking bench for lfsr_burst_ctrl
module tb_lfsr_burst_ctrl;

    logic       clk = 1'b0;
    logic       syncReset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] len = 8'h00;
    logic       abort = 1'b0;
    logic       word_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       word_valid;
    logic [7:0] word_data;

    int assertCount = 0;
    int failCount = 0;

    logic [7:0] words[$];
    logic [7:0] expWords[$];
    bit         readyPat[$];
    int         doneAt;
    int         validCycles;
    int         abortAtValid = -1;
    int         strayStartRel = -1;
    logic       abortedSeen;
    logic       busyAtT1;
    logic       shapeBad;
    logic       holdBad;

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(
        .LEN_W       (8),
        .DEFAULT_SEED(8'h80)
    ) dut (
        .clk       (clk),
        .syncReset (syncReset),
        .start     (start),
        .seed      (seed),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready)
    );

    task automatic expectEq(input string tag, input int got, input int exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkWords(input string tag);
        expectEq({tag, "_count"}, words.size(), expWords.size());
        for (int i = 0; i < expWords.size(); i++) begin
            expectEq($sformatf("%s_word%0d", tag, i),
                     (i < words.size()) ? int'(words[i]) : -1, int'(expWords[i]));
        end
    endtask

    // Issues one start and follows the burst until done; relative cycle 1 is the first sample after the start edge.
    task automatic runBurst(input logic [7:0] s, input logic [7:0] n, input int budget);
        logic [7:0] prevData;
        logic       prevStalled;
        words.delete();
        doneAt      = -1;
        validCycles = 0;
        abortedSeen = 1'b0;
        busyAtT1    = 1'b0;
        shapeBad    = 1'b0;
        holdBad     = 1'b0;
        prevStalled = 1'b0;
        prevData    = 8'h00;
        @(negedge clk);
        seed  = s;
        len   = n;
        start = 1'b1;
        @(posedge clk);
        for (int rel = 1; rel <= budget; rel++) begin
            @(negedge clk);
            start = (rel == strayStartRel);
            if (start) begin
                seed = 8'h33;
                len  = 8'd2;
            end
            if (rel == 1) busyAtT1 = busy;
            if (done) begin
                doneAt      = rel;
                abortedSeen = aborted;
                if (busy || word_valid) shapeBad = 1'b1;
                break;
            end
            if (!busy) shapeBad = 1'b1;
            if (prevStalled && (!word_valid || word_data !== prevData)) holdBad = 1'b1;
            prevStalled = 1'b0;
            word_ready  = 1'b0;
            abort       = 1'b0;
            if (word_valid) begin
                word_ready = (readyPat.size() == 0) ? 1'b1 : readyPat[validCycles % readyPat.size()];
                abort      = (validCycles == abortAtValid);
                if (word_ready && !abort) begin
                    words.push_back(word_data);
                end else if (!abort) begin
                    prevStalled = 1'b1;
                    prevData    = word_data;
                end
                validCycles++;
            end
            @(posedge clk);
        end
        start      = 1'b0;
        word_ready = 1'b0;
        abort      = 1'b0;
    endtask

    initial begin
        int  badWords;
        bit  seen[256];
        logic sawDone;

        repeat (3) @(negedge clk);
        expectEq("reset_busy", busy, 0);
        expectEq("reset_done", done, 0);
        expectEq("reset_aborted", aborted, 0);
        expectEq("reset_valid", word_valid, 0);
        expectEq("reset_data", word_data, 8'h80);
        syncReset = 1'b0;

        // Basic burst with a stray start injected while running
        strayStartRel = 3;
        runBurst(8'h80, 8'd5, 20);
        strayStartRel = -1;
        expWords = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        checkWords("b1");
        expectEq("b1_doneAt", doneAt, 7);
        expectEq("b1_aborted", abortedSeen, 0);
        expectEq("b1_busyT1", busyAtT1, 1);
        expectEq("b1_shape", shapeBad, 0);
        expectEq("b1_persist", word_data, 8'hC4);
        repeat (3) @(negedge clk);
        expectEq("stray_start_busy", busy, 0);
        expectEq("stray_start_data", word_data, 8'hC4);

        // Zero seed falls back to the default seed
        runBurst(8'h00, 8'd3, 20);
        expWords = '{8'h80, 8'h40, 8'h20};
        checkWords("zseed");
        expectEq("zseed_doneAt", doneAt, 5);

        // Back-pressure pattern
        readyPat = '{1, 0, 0, 1, 0, 1, 1};
        runBurst(8'h80, 8'd4, 30);
        readyPat.delete();
        expWords = '{8'h80, 8'h40, 8'h20, 8'h10};
        checkWords("bp");
        expectEq("bp_doneAt", doneAt, 9);
        expectEq("bp_hold", holdBad, 0);
        expectEq("bp_aborted", abortedSeen, 0);

        // Full period
        runBurst(8'h80, 8'd255, 300);
        expectEq("fp_count", words.size(), 255);
        expectEq("fp_doneAt", doneAt, 257);
        badWords = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (words[i]) begin
            if (words[i] == 8'h00 || seen[words[i]]) badWords++;
            seen[words[i]] = 1'b1;
        end
        expectEq("fp_unique_nonzero", badWords, 0);
        expectEq("fp_final_state", word_data, 8'h80);

        // Abort on the third word, then restart at the earliest legal edge
        abortAtValid = 2;
        runBurst(8'h80, 8'd10, 30);
        abortAtValid = -1;
        expWords = '{8'h80, 8'h40};
        checkWords("abort");
        expectEq("abort_doneAt", doneAt, 5);
        expectEq("abort_flag", abortedSeen, 1);
        expectEq("abort_valid_drop", shapeBad, 0);
        expectEq("abort_lfsr_held", word_data, 8'h20);
        runBurst(8'h55, 8'd1, 10);
        expWords = '{8'h55};
        checkWords("restart");
        expectEq("restart_doneAt", doneAt, 3);
        expectEq("restart_aborted", abortedSeen, 0);
        expectEq("restart_state", word_data, 8'hAA);

        // Zero-length burst
        runBurst(8'h12, 8'd0, 10);
        expectEq("len0_doneAt", doneAt, 2);
        expectEq("len0_valid", validCycles, 0);
        expectEq("len0_busyT1", busyAtT1, 1);
        expectEq("len0_aborted", abortedSeen, 0);
        expectEq("len0_lfsr_kept", word_data, 8'hAA);

        // Reset in the middle of RUN
        @(negedge clk);
        seed       = 8'h10;
        len        = 8'd10;
        start      = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        expectEq("rst_running", word_valid, 1);
        syncReset = 1'b1;
        @(negedge clk);
        expectEq("rst_busy", busy, 0);
        expectEq("rst_valid", word_valid, 0);
        expectEq("rst_data", word_data, 8'h80);
        syncReset = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        word_ready = 1'b0;
        expectEq("rst_no_done", sawDone, 0);
        expectEq("rst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
